// File: rtl/bp_be_prefetch_scheduler_pkg.sv
// bp_be_prefetch_scheduler_pkg: shared widths, stream-queue entry and FSM state types
// Holds the address/stride widths used by the scheduler, its queue and its bus interface,
// plus a helper that sign-extends a detector stride to a full virtual address.
package bp_be_prefetch_scheduler_pkg;
    localparam int vaddr_width_gp  = 39;
    localparam int stride_width_gp = 8;
    localparam int degree_width_gp = 4;

    typedef struct packed {
        logic [vaddr_width_gp-1:0]  pc;
        logic [vaddr_width_gp-1:0]  eff_addr;
        logic [stride_width_gp-1:0] stride;
        logic [degree_width_gp-1:0] degree;
    } pf_entry_s;

    typedef enum logic {e_pf_idle, e_pf_issue} pf_state_e;

    function automatic logic [vaddr_width_gp-1:0] sext_stride(input logic [stride_width_gp-1:0] s);
        return {{(vaddr_width_gp-stride_width_gp){s[stride_width_gp-1]}}, s};
    endfunction
endpackage

// File: rtl/bp_be_prefetch_scheduler_if.sv
// bp_be_prefetch_scheduler_if: discovery-event inputs and prefetch request port of the scheduler
// Signal names carry their direction as seen by the scheduler.
//   start_discovery_i / confirm_discovery_i : tentative / confirmed stream event
//   striding_pc_i, eff_addr_i, stride_i     : event payload
//   pf_v_o, pf_addr_o / pf_ready_and_i      : prefetch request valid/ready handshake
// master: the scheduler; slave: the detector + memory-side environment.
interface bp_be_prefetch_scheduler_if;
    import bp_be_prefetch_scheduler_pkg::*;
    logic                       start_discovery_i;
    logic                       confirm_discovery_i;
    logic [vaddr_width_gp-1:0]  striding_pc_i;
    logic [vaddr_width_gp-1:0]  eff_addr_i;
    logic [stride_width_gp-1:0] stride_i;
    logic                       pf_v_o;
    logic [vaddr_width_gp-1:0]  pf_addr_o;
    logic                       pf_ready_and_i;

    modport master (
        input  start_discovery_i, confirm_discovery_i, striding_pc_i, eff_addr_i, stride_i,
        output pf_v_o, pf_addr_o,
        input  pf_ready_and_i
    );
    modport slave (
        output start_discovery_i, confirm_discovery_i, striding_pc_i, eff_addr_i, stride_i,
        input  pf_v_o, pf_addr_o,
        output pf_ready_and_i
    );
endinterface

// File: rtl/bp_be_prefetch_scheduler_fifo.sv
// bp_be_prefetch_scheduler_fifo: small 1-read/1-write FIFO holding pending prefetch streams
// Ports:
//   clk_i, reset_i (async, active-high), flush_i (sync empty)
//   v_i/data_i : write request, accepted when not full or when a read happens this cycle
//   full_o     : all els_p slots occupied
//   v_o/data_o : head entry valid / head entry
//   yumi_i     : consume head (only when v_o)
// els_p must be a power of two >= 2; pointers carry one extra wrap bit to tell full from empty.
module bp_be_prefetch_scheduler_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               full_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int lg_els_lp = $clog2(els_p);

    logic [width_p-1:0] mem_q [els_p];
    logic [lg_els_lp:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic               enq, deq;

    assign v_o    = rptr_q != wptr_q;
    assign full_o = (rptr_q[lg_els_lp] != wptr_q[lg_els_lp])
                 && (rptr_q[lg_els_lp-1:0] == wptr_q[lg_els_lp-1:0]);
    assign deq    = yumi_i & v_o;
    // a write into a full queue is fine when the head leaves in the same cycle
    assign enq    = v_i & (~full_o | deq);
    assign data_o = mem_q[rptr_q[lg_els_lp-1:0]];

    always_comb begin
        rptr_d = flush_i ? '0 : rptr_q + (lg_els_lp+1)'(deq);
        wptr_d = flush_i ? '0 : wptr_q + (lg_els_lp+1)'(enq);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq && !flush_i) mem_q[wptr_q[lg_els_lp-1:0]] <= data_i;
    end
endmodule

// File: rtl/bp_be_prefetch_scheduler.sv
// bp_be_prefetch_scheduler: expands stride-detector stream events into line-aligned prefetch requests
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   enable_i       : 0 drops new events; queued/in-flight streams still drain
//   flush_i        : synchronous flush, empties the queue and abandons the current stream
//   pf_if          : discovery events in, prefetch valid/ready request port out
//   busy_o         : queue non-empty or a stream is being issued
//   dropped_o      : one-cycle pulse, an event was discarded because the queue was full
module bp_be_prefetch_scheduler
    import bp_be_prefetch_scheduler_pkg::*;
#(
    parameter int prefetch_degree_p    = 4,
    parameter int queue_els_p          = 4,
    parameter int block_offset_width_p = 6
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            enable_i,
    input  logic                            flush_i,
    bp_be_prefetch_scheduler_if.master      pf_if,
    output logic                            busy_o,
    output logic                            dropped_o
);
    pf_state_e                  state_q, state_d;
    logic [vaddr_width_gp-1:0]  cur_addr_q, cur_addr_d;
    logic [vaddr_width_gp-1:0]  last_line_q, last_line_d;
    logic [stride_width_gp-1:0] stride_q, stride_d;
    logic [degree_width_gp-1:0] remaining_q, remaining_d;
    logic                       dropped_q, dropped_d;
    pf_entry_s                  enq_entry, deq_entry;
    logic [vaddr_width_gp-1:0]  line;
    logic                       evt, fifo_v, fifo_full, deq, dup, step;

    assign evt = (pf_if.start_discovery_i | pf_if.confirm_discovery_i) & enable_i
               & (|pf_if.stride_i) & ~flush_i;
    assign enq_entry = '{pc:       pf_if.striding_pc_i,
                         eff_addr: pf_if.eff_addr_i,
                         stride:   pf_if.stride_i,
                         degree:   pf_if.confirm_discovery_i ? degree_width_gp'(prefetch_degree_p)
                                                             : degree_width_gp'(1)};
    assign deq  = (state_q == e_pf_idle) & fifo_v & ~flush_i;
    assign line = cur_addr_q & ({vaddr_width_gp{1'b1}} << block_offset_width_p);
    // a line equal to the last one sent is skipped silently, advancing as if accepted
    assign dup  = line == last_line_q;
    assign step = (state_q == e_pf_issue) & ~flush_i & (dup | pf_if.pf_ready_and_i);

    bp_be_prefetch_scheduler_fifo #(
        .width_p ($bits(pf_entry_s)),
        .els_p   (queue_els_p)
    ) queue (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .v_i     (evt),
        .data_i  (enq_entry),
        .full_o  (fifo_full),
        .v_o     (fifo_v),
        .data_o  (deq_entry),
        .yumi_i  (deq)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= e_pf_idle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = flush_i ? e_pf_idle
                : deq ? e_pf_issue
                : (step && remaining_q == degree_width_gp'(1)) ? e_pf_idle
                : state_q;
    end

    always_comb begin
        pf_if.pf_v_o    = (state_q == e_pf_issue) & ~dup;
        pf_if.pf_addr_o = line;
        busy_o          = fifo_v | (state_q != e_pf_idle);
        dropped_o       = dropped_q;
    end

    always_comb begin
        cur_addr_d  = deq ? deq_entry.eff_addr + sext_stride(deq_entry.stride)
                    : step ? cur_addr_q + sext_stride(stride_q) : cur_addr_q;
        stride_d    = deq ? deq_entry.stride : stride_q;
        remaining_d = deq ? deq_entry.degree
                    : step ? remaining_q - degree_width_gp'(1) : remaining_q;
        last_line_d = step ? line : last_line_q;
        // a full queue still takes the event when the head is dequeued this cycle
        dropped_d   = evt & fifo_full & ~deq;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cur_addr_q  <= '0;
            stride_q    <= '0;
            remaining_q <= '0;
            last_line_q <= '0;
            dropped_q   <= 1'b0;
        end else begin
            cur_addr_q  <= cur_addr_d;
            stride_q    <= stride_d;
            remaining_q <= remaining_d;
            last_line_q <= last_line_d;
            dropped_q   <= dropped_d;
        end
    end
endmodule

// File: tb/tb_bp_be_prefetch_scheduler.sv
// tb_bp_be_prefetch_scheduler: directed and random stimulus checked against a queue-based stream model
module tb_bp_be_prefetch_scheduler;
    import bp_be_prefetch_scheduler_pkg::*;
    localparam int V = vaddr_width_gp;
    localparam int S = stride_width_gp;
    localparam int DEG = 4;
    localparam int ELS = 4;
    localparam int BO = 6;

    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    logic enable_i = 1'b0;
    logic flush_i = 1'b0;
    logic busy_o, dropped_o;

    bp_be_prefetch_scheduler_if pf_if();

    bp_be_prefetch_scheduler #(
        .prefetch_degree_p    (DEG),
        .queue_els_p          (ELS),
        .block_offset_width_p (BO)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .enable_i  (enable_i),
        .flush_i   (flush_i),
        .pf_if     (pf_if),
        .busy_o    (busy_o),
        .dropped_o (dropped_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [V-1:0] eff;
        logic [V-1:0] stride;
        int           deg;
    } ent_t;

    ent_t         mq[$];
    bit           m_act, m_drop;
    logic [V-1:0] m_cur, m_str, m_last;
    int           m_rem;
    int           checks, errors;
    logic [V-1:0] log_q[$];
    logic [V-1:0] exp_q[$];

    function automatic logic [V-1:0] lalign(input logic [V-1:0] a);
        return a & ({V{1'b1}} << BO);
    endfunction

    task automatic chk(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_act = 0; m_drop = 0; m_cur = '0; m_str = '0; m_last = '0; m_rem = 0;
    endtask

    task automatic model_step();
        bit ev, full, deq;
        ent_t e;
        ev = (pf_if.start_discovery_i | pf_if.confirm_discovery_i) & enable_i
           & (|pf_if.stride_i) & ~flush_i;
        m_drop = 0;
        if (flush_i) begin
            mq.delete();
            m_act = 0;
            return;
        end
        full = mq.size() == ELS;
        deq = !m_act && mq.size() > 0;
        if (m_act && (lalign(m_cur) == m_last || pf_if.pf_ready_and_i)) begin
            m_last = lalign(m_cur);
            m_cur = m_cur + m_str;
            m_rem--;
            if (m_rem == 0) m_act = 0;
        end
        if (deq) begin
            e = mq.pop_front();
            m_act = 1; m_cur = e.eff + e.stride; m_str = e.stride; m_rem = e.deg;
        end
        if (ev) begin
            if (!full || deq) begin
                e.eff = pf_if.eff_addr_i;
                e.stride = V'($signed(pf_if.stride_i));
                e.deg = pf_if.confirm_discovery_i ? DEG : 1;
                mq.push_back(e);
            end else m_drop = 1;
        end
    endtask

    task automatic check_outputs();
        chk("pf_v", V'(pf_if.pf_v_o), V'(m_act && lalign(m_cur) != m_last));
        if (m_act) chk("pf_addr", pf_if.pf_addr_o, lalign(m_cur));
        chk("busy", V'(busy_o), V'(m_act || mq.size() > 0));
        chk("dropped", V'(dropped_o), V'(m_drop));
    endtask

    task automatic tick();
        if (pf_if.pf_v_o && pf_if.pf_ready_and_i && !flush_i && !reset_i)
            log_q.push_back(pf_if.pf_addr_o);
        @(posedge clk_i);
        if (reset_i) model_reset(); else model_step();
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic send(input bit st, input bit cf, input logic [V-1:0] eff, input logic [S-1:0] str);
        pf_if.start_discovery_i = st;
        pf_if.confirm_discovery_i = cf;
        pf_if.eff_addr_i = eff;
        pf_if.stride_i = str;
        pf_if.striding_pc_i = V'($urandom);
        tick();
        pf_if.start_discovery_i = 0;
        pf_if.confirm_discovery_i = 0;
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_count"}, V'(log_q.size()), V'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk({tag, "_addr"}, (i < log_q.size()) ? log_q[i] : {V{1'bx}}, exp_q[i]);
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pf_if.start_discovery_i = 0;
        pf_if.confirm_discovery_i = 0;
        pf_if.striding_pc_i = '0;
        pf_if.eff_addr_i = '0;
        pf_if.stride_i = '0;
        pf_if.pf_ready_and_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("rst_pf_v", V'(pf_if.pf_v_o), '0);
        chk("rst_pf_addr", pf_if.pf_addr_o, '0);
        chk("rst_busy", V'(busy_o), '0);
        chk("rst_dropped", V'(dropped_o), '0);
        reset_i = 0;
        enable_i = 1;
        pf_if.pf_ready_and_i = 1;
        tick();

        // degree-4 confirmed stream, latency N+2, then idle
        send(0, 1, V'(39'h1000), 8'h40);
        chk("lat_n1_pf_v", V'(pf_if.pf_v_o), '0);
        tick();
        chk("lat_n2_pf_v", V'(pf_if.pf_v_o), V'(1));
        chk("lat_n2_addr", pf_if.pf_addr_o, V'(39'h1040));
        repeat (6) tick();
        exp_q = '{V'(39'h1040), V'(39'h1080), V'(39'h10C0), V'(39'h1100)};
        chk_log("t1");
        chk("t1_busy", V'(busy_o), '0);

        // negative stride tentative stream, zero stride ignored
        send(1, 0, V'(39'h2000), 8'hC0);
        repeat (3) tick();
        send(1, 0, V'(39'h2800), 8'h00);
        chk("t2_zero_busy", V'(busy_o), '0);
        repeat (3) tick();
        exp_q = '{V'(39'h1FC0)};
        chk_log("t2");

        // small stride dedup
        send(0, 1, V'(39'h3000), 8'h08);
        repeat (7) tick();
        send(0, 1, V'(39'h3038), 8'h08);
        repeat (7) tick();
        exp_q = '{V'(39'h3000), V'(39'h3040)};
        chk_log("t3");

        // back-pressure hold plus queue overflow
        pf_if.pf_ready_and_i = 0;
        send(0, 1, V'(39'h4000), 8'h40);
        tick();
        for (int i = 0; i < 4; i++) begin
            send(1, 0, V'(39'h5000) + V'(i) * V'(39'h1000), 8'h40);
            chk("t4_hold_v", V'(pf_if.pf_v_o), V'(1));
            chk("t4_hold_addr", pf_if.pf_addr_o, V'(39'h4040));
        end
        send(1, 0, V'(39'h9000), 8'h40);
        chk("t4_dropped", V'(dropped_o), V'(1));
        repeat (2) tick();
        chk("t4_hold_addr_end", pf_if.pf_addr_o, V'(39'h4040));
        chk("t4_dropped_pulse", V'(dropped_o), '0);
        pf_if.pf_ready_and_i = 1;
        repeat (30) tick();
        exp_q = '{V'(39'h4040), V'(39'h4080), V'(39'h40C0), V'(39'h4100),
                  V'(39'h5040), V'(39'h6040), V'(39'h7040), V'(39'h8040)};
        chk_log("t4");

        // flush with a pending request and two queued streams
        pf_if.pf_ready_and_i = 0;
        send(0, 1, V'(39'hA000), 8'h40);
        tick();
        send(1, 0, V'(39'hB000), 8'h40);
        send(1, 0, V'(39'hC000), 8'h40);
        chk("t5_pre_flush_v", V'(pf_if.pf_v_o), V'(1));
        flush_i = 1;
        tick();
        flush_i = 0;
        chk("t5_flush_v", V'(pf_if.pf_v_o), '0);
        chk("t5_flush_busy", V'(busy_o), '0);
        pf_if.pf_ready_and_i = 1;
        repeat (4) tick();
        chk_log("t5_flush");

        // asynchronous reset while issuing
        pf_if.pf_ready_and_i = 0;
        send(0, 1, V'(39'hD000), 8'h40);
        tick();
        chk("t5_pre_rst_v", V'(pf_if.pf_v_o), V'(1));
        #2 reset_i = 1;
        #1;
        chk("t5_rst_v", V'(pf_if.pf_v_o), '0);
        chk("t5_rst_addr", pf_if.pf_addr_o, '0);
        chk("t5_rst_busy", V'(busy_o), '0);
        @(negedge clk_i);
        reset_i = 0;
        model_reset();
        pf_if.pf_ready_and_i = 1;
        repeat (5) tick();
        chk("t5_post_rst_busy", V'(busy_o), '0);
        chk_log("t5_rst");

        // address wrap at the top of the 39-bit space
        send(1, 0, V'(39'hB000), 8'h40);
        send(1, 0, 39'h7F_FFFF_FFC0, 8'h40);
        repeat (6) tick();
        exp_q = '{V'(39'hB040), V'(39'h0)};
        chk_log("t6");

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            pf_if.start_discovery_i = ($urandom_range(9) < 3);
            pf_if.confirm_discovery_i = ($urandom_range(9) < 2);
            pf_if.striding_pc_i = V'({$urandom, $urandom});
            pf_if.eff_addr_i = V'({$urandom, $urandom});
            pf_if.stride_i = ($urandom_range(7) == 0) ? 8'h00 : S'($urandom);
            enable_i = ($urandom_range(9) != 0);
            flush_i = ($urandom_range(49) == 0);
            pf_if.pf_ready_and_i = ($urandom_range(9) < 7);
            tick();
        end
        log_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
